// File: rtl/hex_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hex_pkg                                                     |
// | Brief  : Shared segment constants, sequencer state type, hex lookup  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package hex_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Active-low segments, bit0 = segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hex_tick_gen                                                |
// | Brief  : Terminal-count divider with enable and synchronous clear    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module hex_tick_gen #(
    parameter int DIV = 25000000
) (
    input  logic CLOCK_50,
    input  logic RESETn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          w_last;

    assign w_last = (cnt_q == CW'(DIV - 1));
    assign tick   = en && !clr && w_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = w_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hex_scroll_ctrl                                             |
// | Brief  : Message buffer and right-to-left scroller for HEX5..HEX0    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module hex_scroll_ctrl
    import hex_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 25000000,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic          CLOCK_50,
    input  logic          RESETn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_data,
    output logic          wr_ready,
    input  logic [AW:0]   len,
    input  logic          start,
    input  logic          pause,
    input  logic          stop,
    output logic          busy,
    output logic [6:0]    HEX0,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX4,
    output logic [6:0]    HEX5
);

    state_t        state_q, state_d;
    logic [AW-1:0] offset_q, offset_d;
    logic [AW:0]   len_q, len_d;
    logic [6:0]    msg_q [DEPTH];
    logic [6:0]    msg_d [DEPTH];
    logic [6:0]    hex_q [6];
    logic [6:0]    hex_d [6];
    logic [AW:0]   pos;

    logic w_start_ok;
    logic w_wr_ok;
    logic w_tick_en;
    logic w_tick_clr;
    logic w_tick;

    assign w_start_ok = start && (len >= (AW+1)'(6)) && (len <= (AW+1)'(DEPTH));
    assign w_wr_ok    = wr_en && (state_q != RUN) && ({1'b0, wr_addr} < (AW+1)'(DEPTH));
    // The counter freezes in the very cycle pause or stop is seen.
    assign w_tick_en  = (state_q == RUN) && !stop && !pause;
    assign w_tick_clr = (state_q == IDLE) || stop;

    hex_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .CLOCK_50 (CLOCK_50),
        .RESETn   (RESETn),
        .en       (w_tick_en),
        .clr      (w_tick_clr),
        .tick     (w_tick)
    );

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        len_d    = len_q;
        case (state_q)
            IDLE: begin
                offset_d = '0;
                if (w_start_ok) begin
                    state_d = RUN;
                    len_d   = len;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d  = IDLE;
                    offset_d = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (w_tick) begin
                    offset_d = (({1'b0, offset_q} + (AW+1)'(1)) == len_q) ? '0 : offset_q + 1'b1;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d  = IDLE;
                    offset_d = '0;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d  = IDLE;
                offset_d = '0;
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            msg_d[k] = msg_q[k];
        end
        if (w_wr_ok) begin
            msg_d[wr_addr] = wr_data;
        end
    end

    // len_q >= 6 in RUN/PAUSE, so one conditional subtract wraps the window.
    always_comb begin
        pos = '0;
        for (int i = 0; i < 6; i++) begin
            pos = {1'b0, offset_q} + (AW+1)'(i);
            if (state_q == IDLE) begin
                pos = (AW+1)'(i);
            end else if (pos >= len_q) begin
                pos = pos - len_q;
            end
            hex_d[5-i] = msg_q[pos[AW-1:0]];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= IDLE;
            offset_q <= '0;
            len_q    <= (AW+1)'(6);
            for (int k = 0; k < DEPTH; k++) begin
                msg_q[k] <= SEG_BLANK;
            end
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            len_q    <= len_d;
            for (int k = 0; k < DEPTH; k++) begin
                msg_q[k] <= msg_d[k];
            end
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign wr_ready = (state_q != RUN);
    assign HEX0     = hex_q[0];
    assign HEX1     = hex_q[1];
    assign HEX2     = hex_q[2];
    assign HEX3     = hex_q[3];
    assign HEX4     = hex_q[4];
    assign HEX5     = hex_q[5];

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_hex_scroll_ctrl                                          |
// | Brief  : Directed, table-driven bench for hex_scroll_ctrl            |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_hex_scroll_ctrl;

    localparam int DEPTH    = 16;
    localparam int TICK_DIV = 4;
    localparam int AW       = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic          wr_ready;
    logic [AW:0]   len;
    logic          start, pause, stop;
    logic          busy;
    logic [6:0]    HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    always #5 clk = ~clk;

    hex_scroll_ctrl #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .CLOCK_50 (clk),
        .RESETn   (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .len      (len),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .busy     (busy),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    typedef struct {
        int   n;
        int   off;
        logic busy;
    } vec_t;

    vec_t       tbl [8];
    logic [6:0] mem [DEPTH];
    int         n_pass  = 0;
    int         n_total = 0;
    int         cur     = 0;

    wire [41:0] hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

    task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [41:0] win(input int off, input int ln);
        logic [41:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[41-7*i -: 7] = mem[(off + i) % ln];
        end
        return win_ret(r);
    endfunction

    function automatic logic [41:0] win_ret(input logic [41:0] r);
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        cur += n;
    endtask

    initial begin
        tbl[0] = '{1,  0, 1'b1};
        tbl[1] = '{4,  0, 1'b1};
        tbl[2] = '{5,  1, 1'b1};
        tbl[3] = '{9,  2, 1'b1};
        tbl[4] = '{13, 3, 1'b1};
        tbl[5] = '{17, 4, 1'b1};
        tbl[6] = '{29, 7, 1'b1};
        tbl[7] = '{33, 0, 1'b1};

        for (int k = 0; k < DEPTH; k++) mem[k] = 7'h7F;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = 5'd6; start = 1'b0; pause = 1'b0; stop = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("reset_hex",      hex_all, ALL_BLANK);
        chk("reset_busy",     42'(busy), 42'd0);
        chk("reset_wr_ready", 42'(wr_ready), 42'd1);

        for (int k = 0; k < 8; k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = 7'h40 + 7'(k);
            mem[k] = 7'h40 + 7'(k);
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("idle_window", hex_all, win(0, 8));

        start = 1'b1; len = 5'd5;
        repeat (2) @(negedge clk);
        chk("len5_busy", 42'(busy), 42'd0);
        chk("len5_hex",  hex_all, win(0, 8));
        len = 5'd17;
        repeat (2) @(negedge clk);
        chk("len17_busy", 42'(busy), 42'd0);
        chk("len17_hex",  hex_all, win(0, 8));
        start = 1'b0;
        @(negedge clk);

        // Scroll: cur counts cycles since the accepting start edge.
        start = 1'b1; len = 5'd8;
        @(negedge clk);
        start = 1'b0;
        cur = 0;
        for (int v = 0; v < 8; v++) begin
            cyc(tbl[v].n - cur);
            chk($sformatf("run_busy_n%0d", tbl[v].n), 42'(busy), 42'(tbl[v].busy));
            chk($sformatf("run_hex_n%0d", tbl[v].n), hex_all, win(tbl[v].off, 8));
        end

        // Pause two cycles into a step; write inside the visible window.
        cyc(1);
        pause = 1'b1;
        cyc(1);
        chk("pause_busy",     42'(busy), 42'd1);
        chk("pause_wr_ready", 42'(wr_ready), 42'd1);
        cyc(2);
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 7'h00;
        cyc(1);
        wr_en = 1'b0;
        chk("pause_write_latency", 42'(HEX3), 42'h42);
        mem[2] = 7'h00;
        cyc(1);
        chk("pause_write_visible", hex_all, win(0, 8));
        cyc(5);
        chk("pause_frozen", hex_all, win(0, 8));
        pause = 1'b0;
        cyc(3);
        chk("resume_before_shift", hex_all, win(0, 8));
        cyc(1);
        chk("resume_shift", hex_all, win(1, 8));

        // stop wins over pause and start; RUN-time write is dropped.
        stop = 1'b1; start = 1'b1; pause = 1'b1; len = 5'd8;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 7'h11;
        cyc(1);
        stop = 1'b0; start = 1'b0; pause = 1'b0; wr_en = 1'b0;
        chk("stop_busy",     42'(busy), 42'd0);
        chk("stop_wr_ready", 42'(wr_ready), 42'd1);
        cyc(1);
        chk("stop_hex_offset0", hex_all, win(0, 8));

        // Write accepted in the same cycle as an accepted start.
        start = 1'b1; len = 5'd8;
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 7'h22;
        cyc(1);
        start = 1'b0; wr_en = 1'b0;
        mem[1] = 7'h22;
        chk("start_wr_busy",     42'(busy), 42'd1);
        chk("start_wr_ready",    42'(wr_ready), 42'd0);
        cyc(1);
        chk("start_wr_hex", hex_all, win(0, 8));
        cyc(4);
        chk("restart_shift", hex_all, win(1, 8));

        // Asynchronous reset in the middle of RUN.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_hex",      hex_all, ALL_BLANK);
        chk("async_rst_busy",     42'(busy), 42'd0);
        chk("async_rst_wr_ready", 42'(wr_ready), 42'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) mem[k] = 7'h7F;
        repeat (2) @(negedge clk);
        chk("post_rst_buffer_blank", hex_all, win(0, 8));
        chk("post_rst_idle",         42'(busy), 42'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
